// File: rtl/sirv_plic_claim_master.sv
// ============================================================================
// Module   : sirv_plic_claim_master
// Purpose  : ICB initiator that claims PLIC interrupts, hands the ID to a local
//            handler and writes the ID back to complete it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sirv_plic_claim_master #(
    parameter logic [31:0] CLAIM_ADDR = 32'h0C20_0004,
    parameter int          IRQ_ID_W   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                plic_irq,
    output logic                o_icb_cmd_valid,
    input  logic                o_icb_cmd_ready,
    output logic [31:0]         o_icb_cmd_addr,
    output logic                o_icb_cmd_read,
    output logic [31:0]         o_icb_cmd_wdata,
    input  logic                o_icb_rsp_valid,
    output logic                o_icb_rsp_ready,
    input  logic [31:0]         o_icb_rsp_rdata,
    input  logic                o_icb_rsp_err,
    output logic                irq_id_valid,
    input  logic                irq_id_ready,
    output logic [IRQ_ID_W-1:0] irq_id,
    input  logic                irq_done,
    output logic                busy,
    output logic                err,
    output logic [7:0]          spur_cnt
);

    localparam int c_WDATA_PAD = 32 - IRQ_ID_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLM_CMD   = 3'd1,
        S_CLM_RSP   = 3'd2,
        S_DISPATCH  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_CMP_CMD   = 3'd5,
        S_CMP_RSP   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IRQ_ID_W-1:0] r_irq_id;
    logic [7:0]          r_spur_cnt;
    logic                r_err;

    logic [IRQ_ID_W-1:0] w_claim_id;
    logic                w_claim_zero;
    logic                w_claim_rsp;
    logic                w_unused_rdata;

    // Only the low ID bits of the claim word carry meaning.
    assign w_claim_id     = o_icb_rsp_rdata[IRQ_ID_W-1:0];
    assign w_claim_zero   = (w_claim_id == '0);
    assign w_claim_rsp    = (r_state == S_CLM_RSP) && o_icb_rsp_valid && !o_icb_rsp_err;
    assign w_unused_rdata = ^o_icb_rsp_rdata[31:IRQ_ID_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_irq_id   <= '0;
            r_spur_cnt <= 8'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= o_icb_rsp_valid && o_icb_rsp_ready && o_icb_rsp_err;
            if (w_claim_rsp && !w_claim_zero) begin
                r_irq_id <= w_claim_id;
            end
            if (w_claim_rsp && w_claim_zero && (r_spur_cnt != 8'hFF)) begin
                r_spur_cnt <= r_spur_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (en && plic_irq) w_state_nxt = S_CLM_CMD;
            end
            S_CLM_CMD: begin
                if (o_icb_cmd_ready) w_state_nxt = S_CLM_RSP;
            end
            S_CLM_RSP: begin
                if (o_icb_rsp_valid) begin
                    // Errored or spurious claims have nothing to complete.
                    if (o_icb_rsp_err || w_claim_zero) w_state_nxt = S_IDLE;
                    else                               w_state_nxt = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (irq_id_ready) w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (irq_done) w_state_nxt = S_CMP_CMD;
            end
            S_CMP_CMD: begin
                if (o_icb_cmd_ready) w_state_nxt = S_CMP_RSP;
            end
            S_CMP_RSP: begin
                if (o_icb_rsp_valid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // All handshake outputs decode from registered state only.
    always_comb begin
        o_icb_cmd_valid = 1'b0;
        o_icb_cmd_read  = 1'b1;
        o_icb_cmd_wdata = 32'd0;
        o_icb_rsp_ready = 1'b0;
        irq_id_valid    = 1'b0;
        case (r_state)
            S_CLM_CMD: o_icb_cmd_valid = 1'b1;
            S_CLM_RSP: o_icb_rsp_ready = 1'b1;
            S_DISPATCH: irq_id_valid   = 1'b1;
            S_CMP_CMD: begin
                o_icb_cmd_valid = 1'b1;
                o_icb_cmd_read  = 1'b0;
                o_icb_cmd_wdata = {{c_WDATA_PAD{1'b0}}, r_irq_id};
            end
            S_CMP_RSP: o_icb_rsp_ready = 1'b1;
            default: ;
        endcase
    end

    assign o_icb_cmd_addr = CLAIM_ADDR;
    assign irq_id         = r_irq_id;
    assign busy           = (r_state != S_IDLE);
    assign err            = r_err;
    assign spur_cnt       = r_spur_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sirv_plic_claim_master.sv
// ============================================================================
// Module   : tb_sirv_plic_claim_master
// Purpose  : Directed self-checking bench for sirv_plic_claim_master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sirv_plic_claim_master;

    localparam logic [31:0] c_ADDR = 32'h0C20_0004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        plic_irq = 1'b0;
    logic        o_icb_cmd_valid;
    logic        o_icb_cmd_ready = 1'b0;
    logic [31:0] o_icb_cmd_addr;
    logic        o_icb_cmd_read;
    logic [31:0] o_icb_cmd_wdata;
    logic        o_icb_rsp_valid = 1'b0;
    logic        o_icb_rsp_ready;
    logic [31:0] o_icb_rsp_rdata = 32'd0;
    logic        o_icb_rsp_err = 1'b0;
    logic        irq_id_valid;
    logic        irq_id_ready = 1'b0;
    logic [5:0]  irq_id;
    logic        irq_done = 1'b0;
    logic        busy;
    logic        err;
    logic [7:0]  spur_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_cmd_hs = 0;
    int hs_mark;

    sirv_plic_claim_master #(
        .CLAIM_ADDR (c_ADDR),
        .IRQ_ID_W   (6)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .plic_irq        (plic_irq),
        .o_icb_cmd_valid (o_icb_cmd_valid),
        .o_icb_cmd_ready (o_icb_cmd_ready),
        .o_icb_cmd_addr  (o_icb_cmd_addr),
        .o_icb_cmd_read  (o_icb_cmd_read),
        .o_icb_cmd_wdata (o_icb_cmd_wdata),
        .o_icb_rsp_valid (o_icb_rsp_valid),
        .o_icb_rsp_ready (o_icb_rsp_ready),
        .o_icb_rsp_rdata (o_icb_rsp_rdata),
        .o_icb_rsp_err   (o_icb_rsp_err),
        .irq_id_valid    (irq_id_valid),
        .irq_id_ready    (irq_id_ready),
        .irq_id          (irq_id),
        .irq_done        (irq_done),
        .busy            (busy),
        .err             (err),
        .spur_cnt        (spur_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_icb_cmd_valid && o_icb_cmd_ready) n_cmd_hs <= n_cmd_hs + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic serve_cmd(input string tag, input logic exp_read,
                             input logic [31:0] exp_wdata, input int stall);
        int i = 0;
        while (!o_icb_cmd_valid && i < 20) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_valid"}, 32'(o_icb_cmd_valid), 32'd1);
        check({tag, "_addr"}, o_icb_cmd_addr, c_ADDR);
        check({tag, "_read"}, 32'(o_icb_cmd_read), 32'(exp_read));
        check({tag, "_wdata"}, o_icb_cmd_wdata, exp_wdata);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(o_icb_cmd_valid), 32'd1);
            check({tag, "_hold_addr"}, o_icb_cmd_addr, c_ADDR);
            check({tag, "_hold_read"}, 32'(o_icb_cmd_read), 32'(exp_read));
            check({tag, "_hold_wdata"}, o_icb_cmd_wdata, exp_wdata);
        end
        o_icb_cmd_ready = 1'b1;
        @(negedge clk);
        o_icb_cmd_ready = 1'b0;
        check({tag, "_cmd_drop"}, 32'(o_icb_cmd_valid), 32'd0);
        check({tag, "_rsp_ready"}, 32'(o_icb_rsp_ready), 32'd1);
        check({tag, "_wdata_idle"}, o_icb_cmd_wdata, 32'd0);
    endtask

    task automatic serve_rsp(input logic [31:0] rdata, input logic rerr);
        o_icb_rsp_valid = 1'b1;
        o_icb_rsp_rdata = rdata;
        o_icb_rsp_err   = rerr;
        @(negedge clk);
        o_icb_rsp_valid = 1'b0;
        o_icb_rsp_rdata = 32'd0;
        o_icb_rsp_err   = 1'b0;
    endtask

    // Full claim from IDLE: irq one cycle, then claim read and its response.
    task automatic claim(input string tag, input logic [31:0] rdata,
                         input logic rerr, input int stall);
        plic_irq = 1'b1;
        @(negedge clk);
        plic_irq = 1'b0;
        check({tag, "_latency"}, 32'(o_icb_cmd_valid), 32'd1);
        serve_cmd(tag, 1'b1, 32'd0, stall);
        serve_rsp(rdata, rerr);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cmd_valid", 32'(o_icb_cmd_valid), 32'd0);
        check("rst_cmd_read", 32'(o_icb_cmd_read), 32'd1);
        check("rst_cmd_addr", o_icb_cmd_addr, c_ADDR);
        check("rst_wdata", o_icb_cmd_wdata, 32'd0);
        check("rst_rsp_ready", 32'(o_icb_rsp_ready), 32'd0);
        check("rst_id_valid", 32'(irq_id_valid), 32'd0);
        check("rst_irq_id", 32'(irq_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_spur", 32'(spur_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;

        // Basic claim / dispatch / complete of ID 5
        irq_id_ready = 1'b1;
        claim("t1_clm", 32'h0000_0005, 1'b0, 0);
        check("t1_id_valid", 32'(irq_id_valid), 32'd1);
        check("t1_irq_id", 32'(irq_id), 32'd5);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        irq_id_ready = 1'b0;
        check("t1_id_valid_drop", 32'(irq_id_valid), 32'd0);
        repeat (2) @(negedge clk);
        check("t1_wait_no_cmd", 32'(o_icb_cmd_valid), 32'd0);
        irq_done = 1'b1;
        @(negedge clk);
        irq_done = 1'b0;
        check("t1_cmp_latency", 32'(o_icb_cmd_valid), 32'd1);
        serve_cmd("t1_cmp", 1'b0, 32'h0000_0005, 0);
        serve_rsp(32'hDEAD_BEEF, 1'b0);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_err_none", 32'(err), 32'd0);

        // Spurious claims (upper bits set but ID field zero counts as spurious)
        hs_mark = n_cmd_hs;
        claim("t2_sp0", 32'h0000_0000, 1'b0, 0);
        check("t2_no_dispatch0", 32'(irq_id_valid), 32'd0);
        check("t2_idle0", 32'(busy), 32'd0);
        claim("t2_sp1", 32'hFFFF_FFC0, 1'b0, 0);
        check("t2_no_dispatch1", 32'(irq_id_valid), 32'd0);
        claim("t2_sp2", 32'h0000_0000, 1'b0, 0);
        claim("t2_sp3", 32'h0000_0040, 1'b0, 0);
        check("t2_spur4", 32'(spur_cnt), 32'd4);
        check("t2_no_writes", 32'(n_cmd_hs - hs_mark), 32'd4);
        check("t2_id_held", 32'(irq_id), 32'd5);
        for (int n = 0; n < 251; n++) claim("t2_fill", 32'd0, 1'b0, 0);
        check("t2_spur255", 32'(spur_cnt), 32'd255);
        claim("t2_sat", 32'd0, 1'b0, 0);
        check("t2_spur_sat", 32'(spur_cnt), 32'd255);

        // Command stalls on both transactions; claim word with upper junk -> ID 42
        hs_mark = n_cmd_hs;
        claim("t3_clm", 32'h0000_01EA, 1'b0, 5);
        check("t3_id_valid", 32'(irq_id_valid), 32'd1);
        check("t3_irq_id", 32'(irq_id), 32'd42);
        @(negedge clk);
        check("t3_id_hold", 32'(irq_id_valid), 32'd1);
        irq_id_ready = 1'b1;
        @(negedge clk);
        irq_id_ready = 1'b0;
        irq_done = 1'b1;
        @(negedge clk);
        irq_done = 1'b0;
        serve_cmd("t3_cmp", 1'b0, 32'd42, 5);
        serve_rsp(32'd0, 1'b0);
        check("t3_two_txn", 32'(n_cmd_hs - hs_mark), 32'd2);
        check("t3_busy_end", 32'(busy), 32'd0);

        // Claim response error
        claim("t4_clm", 32'h0000_0005, 1'b1, 0);
        check("t4_err_pulse", 32'(err), 32'd1);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_no_dispatch", 32'(irq_id_valid), 32'd0);
        @(negedge clk);
        check("t4_err_one_cycle", 32'(err), 32'd0);
        check("t4_no_dispatch2", 32'(irq_id_valid), 32'd0);
        check("t4_id_held", 32'(irq_id), 32'd42);

        // irq_done in DISPATCH handshake ignored; en dropped during WAIT_DONE
        claim("t5_clm", 32'h0000_0007, 1'b0, 0);
        check("t5_id_valid", 32'(irq_id_valid), 32'd1);
        irq_id_ready = 1'b1;
        irq_done     = 1'b1;
        @(negedge clk);
        irq_id_ready = 1'b0;
        irq_done     = 1'b0;
        en           = 1'b0;
        plic_irq     = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_early_done_ignored", 32'(o_icb_cmd_valid), 32'd0);
        check("t5_still_busy", 32'(busy), 32'd1);
        irq_done = 1'b1;
        @(negedge clk);
        irq_done = 1'b0;
        serve_cmd("t5_cmp", 1'b0, 32'd7, 0);
        serve_rsp(32'd0, 1'b1);
        check("t5_cmp_err", 32'(err), 32'd1);
        check("t5_idle", 32'(busy), 32'd0);
        hs_mark = n_cmd_hs;
        repeat (5) @(negedge clk);
        check("t5_parked", 32'(busy), 32'd0);
        check("t5_no_claim", 32'(n_cmd_hs - hs_mark), 32'd0);

        // Async reset in CMP_CMD, then fresh claim
        en = 1'b1;
        @(negedge clk);
        plic_irq = 1'b0;
        check("t6_latency", 32'(o_icb_cmd_valid), 32'd1);
        serve_cmd("t6_clm", 1'b1, 32'd0, 0);
        serve_rsp(32'h0000_0009, 1'b0);
        irq_id_ready = 1'b1;
        @(negedge clk);
        irq_id_ready = 1'b0;
        irq_done = 1'b1;
        @(negedge clk);
        irq_done = 1'b0;
        check("t6_in_cmp", o_icb_cmd_wdata, 32'd9);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_cmd_valid", 32'(o_icb_cmd_valid), 32'd0);
        check("t6_rst_read", 32'(o_icb_cmd_read), 32'd1);
        check("t6_rst_wdata", o_icb_cmd_wdata, 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_irq_id", 32'(irq_id), 32'd0);
        check("t6_rst_spur", 32'(spur_cnt), 32'd0);
        @(negedge clk);
        plic_irq = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        plic_irq = 1'b0;
        check("t6_fresh_claim", 32'(o_icb_cmd_valid), 32'd1);
        serve_cmd("t6_reclm", 1'b1, 32'd0, 0);
        serve_rsp(32'd0, 1'b0);
        check("t6_spur_after_rst", 32'(spur_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
